// File: rtl/fir_rns_sequencer.sv
// Frame controller for the RNS FIR datapath: loads SIGNAL_LENGTH samples into the
// filter, runs and times the convolution, then streams every result out.
`timescale 1ns/1ps
module fir_rns_sequencer #(
  parameter int N             = 100,
  parameter int SIGNAL_LENGTH = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        fir_reset,
  output logic [1:0]  fir_operation,
  output logic [31:0] fir_addr,
  output logic [31:0] fir_x_rns,
  input  logic [31:0] fir_y_rns,
  input  logic        fir_done,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [31:0] compute_cycles
);

  if (N < 1 || SIGNAL_LENGTH < 1) begin : g_param_check
    $error("fir_rns_sequencer: N and SIGNAL_LENGTH must be positive");
  end

  typedef enum logic [2:0] {
    S_CLEAR, S_LOAD, S_COMPUTE, S_RD_REQ, S_RD_WAIT, S_RD_OUT
  } state_t;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_COMPUTE = 2'b10,
    OP_READ    = 2'b11
  } op_t;

  localparam logic [31:0] LAST_IDX = 32'(SIGNAL_LENGTH - 1);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic        fir_reset_q, fir_reset_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] x_q, x_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] k_q, k_d;
  logic [31:0] run_q, run_d;
  logic [31:0] cc_q, cc_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        busy_q, busy_d;
  logic [15:0] frame_q, frame_d;
  logic [31:0] run_inc;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fir_reset_d = fir_reset_q;
    addr_d      = addr_q;
    x_d         = x_q;
    idx_d       = idx_q;
    k_d         = k_q;
    run_d       = run_q;
    cc_d        = cc_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    frame_d     = frame_q;
    run_inc     = run_q + {31'b0, op_q == OP_COMPUTE};

    unique case (state_q)
      S_CLEAR: begin
        fir_reset_d = 1'b0;
        op_d        = OP_IDLE;
        idx_d       = '0;
        run_d       = '0;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        if (s_valid) begin
          op_d   = OP_WRITE;
          addr_d = idx_q;
          x_d    = s_data;
          idx_d  = idx_q + 32'd1;
          if (idx_q == LAST_IDX) begin
            run_d   = '0;
            state_d = S_COMPUTE;
          end
        end else begin
          op_d = OP_IDLE;
        end
      end
      S_COMPUTE: begin
        run_d = run_inc;
        if (fir_done) begin
          op_d    = OP_IDLE;
          cc_d    = run_inc;
          k_d     = '0;
          state_d = S_RD_REQ;
        end else begin
          op_d = OP_COMPUTE;
        end
      end
      S_RD_REQ: begin
        op_d    = OP_READ;
        addr_d  = k_q;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Two cycles: read command on the bus, then the filter's registered data.
        if (op_q == OP_READ) begin
          op_d = OP_IDLE;
        end else begin
          m_data_d  = fir_y_rns;
          m_valid_d = 1'b1;
          m_last_d  = (k_q == LAST_IDX);
          state_d   = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (k_q == LAST_IDX) begin
            frame_d     = frame_q + 16'd1;
            fir_reset_d = 1'b1;
            state_d     = S_CLEAR;
          end else begin
            // Next read is issued on the handshake edge to keep a 3-cycle result rate.
            k_d     = k_q + 32'd1;
            op_d    = OP_READ;
            addr_d  = k_q + 32'd1;
            state_d = S_RD_WAIT;
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    busy_d = !(state_d == S_LOAD && idx_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      op_q        <= OP_IDLE;
      fir_reset_q <= 1'b1;
      addr_q      <= '0;
      x_q         <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      run_q       <= '0;
      cc_q        <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b1;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fir_reset_q <= fir_reset_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      run_q       <= run_d;
      cc_q        <= cc_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      frame_q     <= frame_d;
    end
  end

  assign s_ready        = (state_q == S_LOAD);
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign m_last         = m_last_q;
  assign fir_reset      = fir_reset_q;
  assign fir_operation  = op_q;
  assign fir_addr       = addr_q;
  assign fir_x_rns      = x_q;
  assign busy           = busy_q;
  assign frame_count    = frame_q;
  assign compute_cycles = cc_q;

endmodule

// File: tb/tb_fir_rns_sequencer.sv
// Directed bench for fir_rns_sequencer with a behavioural RNS FIR filter on its
// command port; expected results are hand-computed 4-tap convolutions.
`timescale 1ns/1ps
module tb_fir_rns_sequencer;

  localparam int N  = 4;
  localparam int SL = 8;
  localparam int AW = $clog2(SL);
  localparam int unsigned COMPUTE_LEN = SL * (N + 1) + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        fir_reset;
  logic [1:0]  fir_operation;
  logic [31:0] fir_addr;
  logic [31:0] fir_x_rns;
  logic [31:0] fir_y_rns = '0;
  logic        fir_done = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic [31:0] compute_cycles;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int excl_bad = 0;
  int cur_mode = 0;

  // Hand-computed outputs, identical in every residue byte.
  int exp_ramp [SL] = '{0, 1, 3, 6, 10, 14, 18, 22};   // x=k,    h=1
  int exp_odd  [SL] = '{1, 4, 9, 16, 24, 32, 40, 48};  // x=2k+1, h=1
  int exp_sat  [SL] = '{1, 2, 3, 4, 4, 4, 4, 4};       // x=h=m-1, (m-1)^2 = 1 mod m

  fir_rns_sequencer #(.N(N), .SIGNAL_LENGTH(SL)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .fir_reset(fir_reset), .fir_operation(fir_operation), .fir_addr(fir_addr),
    .fir_x_rns(fir_x_rns), .fir_y_rns(fir_y_rns), .fir_done(fir_done),
    .busy(busy), .frame_count(frame_count), .compute_cycles(compute_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (fir_reset && fir_operation != 2'b00) excl_bad <= excl_bad + 1;

  // ---------------- behavioural filter ----------------
  logic [31:0] mem [SL];
  int unsigned coef [4];
  int unsigned model_cc = 0;
  int unsigned wr_n = 0;
  int unsigned wr_bad = 0;

  function automatic int unsigned modulus(input int b);
    case (b)
      3:       return 251;
      2:       return 241;
      1:       return 239;
      default: return 233;
    endcase
  endfunction

  function automatic logic [31:0] sample(input int mode, input int k);
    logic [7:0] v;
    v = 8'((mode == 0) ? k : 2 * k + 1);
    if (mode == 2) return {8'd250, 8'd240, 8'd238, 8'd232};
    return {v, v, v, v};
  endfunction

  function automatic logic [31:0] expected(input int mode, input int k);
    logic [7:0] e;
    e = 8'((mode == 0) ? exp_ramp[k] : (mode == 1) ? exp_odd[k] : exp_sat[k]);
    return {e, e, e, e};
  endfunction

  function automatic logic [31:0] conv(input int k);
    logic [31:0] r;
    int unsigned acc;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      acc = 0;
      for (int j = 0; j < N; j++)
        if (k - j >= 0) acc = acc + coef[b] * 32'(mem[AW'(k - j)][8*b +: 8]);
      r[8*b +: 8] = 8'(acc % modulus(b));
    end
    return r;
  endfunction

  // fir_done is registered, so it rises one edge before the last compute cycle ends.
  always @(posedge clk) begin
    if (fir_reset) begin
      model_cc <= 0;
      fir_done <= 1'b0;
      wr_n     <= 0;
      wr_bad   <= 0;
      for (int i = 0; i < SL; i++) mem[i] <= '0;
    end else begin
      case (fir_operation)
        2'b01: begin
          mem[fir_addr[AW-1:0]] <= fir_x_rns;
          if (fir_addr != wr_n || fir_x_rns != sample(cur_mode, int'(fir_addr)))
            wr_bad <= wr_bad + 1;
          wr_n <= wr_n + 1;
        end
        2'b10: begin
          model_cc <= model_cc + 1;
          if (model_cc + 1 >= COMPUTE_LEN - 1) fir_done <= 1'b1;
        end
        2'b11: fir_y_rns <= conv(int'(fir_addr));
        default: ;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input bit chk_now);
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    if (chk_now) begin
      chk("async fir_reset", fir_reset, 1);
      chk("async op", fir_operation, 0);
      chk("async m_valid", m_valid, 0);
      chk("async frame_count", frame_count, 0);
    end
    repeat (3) tick();
    chk("rst s_ready", s_ready, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst m_last", m_last, 0);
    chk("rst fir_reset", fir_reset, 1);
    chk("rst op", fir_operation, 0);
    chk("rst addr", fir_addr, 0);
    chk("rst x_rns", fir_x_rns, 0);
    chk("rst busy", busy, 1);
    chk("rst frame_count", frame_count, 0);
    chk("rst compute_cycles", compute_cycles, 0);
    reset = 1'b1;
    chk("rel1 s_ready", s_ready, 0);
    chk("rel1 fir_reset", fir_reset, 1);
    tick();
    chk("rel2 s_ready", s_ready, 1);
    chk("rel2 fir_reset", fir_reset, 0);
    chk("rel2 busy", busy, 0);
  endtask

  task automatic load_frame(input int mode, input bit gap);
    int budget;
    cur_mode = mode;
    budget = 0;
    while (!s_ready && budget < 50) begin tick(); budget++; end
    chk("load s_ready", s_ready, 1);
    for (int k = 0; k < SL; k++) begin
      s_valid = 1'b1;
      s_data  = sample(mode, k);
      tick();
      s_valid = 1'b0;
      chk($sformatf("wr op k%0d", k), fir_operation, 1);
      chk($sformatf("wr addr k%0d", k), fir_addr, k);
      chk($sformatf("wr data k%0d", k), fir_x_rns, sample(mode, k));
      if (gap && k < SL - 1) begin
        repeat (2) begin
          tick();
          chk($sformatf("gap op k%0d", k), fir_operation, 0);
        end
      end
    end
    chk("post-load s_ready", s_ready, 0);
    chk("post-load busy", busy, 1);
  endtask

  task automatic read_frame(input int mode, input bit hold_ready, input int stall_k,
                            input int exp_frames);
    int budget;
    int last_cyc;
    m_ready  = hold_ready;
    last_cyc = 0;
    for (int k = 0; k < SL; k++) begin
      budget = 0;
      while (!m_valid && budget < 200) begin tick(); budget++; end
      chk($sformatf("rd valid k%0d", k), m_valid, 1);
      chk($sformatf("rd data k%0d", k), m_data, expected(mode, k));
      chk($sformatf("rd last k%0d", k), m_last, (k == SL - 1) ? 1 : 0);
      if (k == 0) begin
        chk("compute_cycles", compute_cycles, COMPUTE_LEN);
        chk("writes seen", wr_n, SL);
        chk("bad writes", wr_bad, 0);
      end
      if (hold_ready && k > 0) chk($sformatf("rd period k%0d", k), 32'(cyc - last_cyc), 3);
      last_cyc = cyc;
      if (k == stall_k) begin
        m_ready = 1'b0;
        repeat (2) begin
          tick();
          chk("stall valid", m_valid, 1);
          chk("stall data", m_data, expected(mode, k));
          chk("stall last", m_last, 0);
        end
      end
      m_ready = 1'b1;
      tick();
      m_ready = hold_ready;
      chk($sformatf("post-hs valid k%0d", k), m_valid, 0);
    end
    m_ready = 1'b0;
    chk("frame_count", frame_count, exp_frames);
    chk("turn s_ready edge1", s_ready, 0);
    chk("turn fir_reset edge1", fir_reset, 1);
    tick();
    chk("turn s_ready edge2", s_ready, 1);
    chk("turn fir_reset edge2", fir_reset, 0);
    chk("turn busy edge2", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int budget;
    for (int b = 0; b < 4; b++) coef[b] = 1;
    apply_reset(1'b0);

    // Frame 1: contiguous load, backpressured readout.
    load_frame(0, 1'b0);
    read_frame(0, 1'b0, 3, 1);

    // Frame 2: gapped load, different data, m_ready held high.
    load_frame(1, 1'b1);
    read_frame(1, 1'b1, -1, 2);

    // Reset during compute.
    load_frame(0, 1'b0);
    repeat (5) tick();
    chk("mid-compute op", fir_operation, 2);
    apply_reset(1'b1);

    // Reset while a result is waiting in RD_OUT.
    load_frame(1, 1'b0);
    budget = 0;
    while (!m_valid && budget < 200) begin tick(); budget++; end
    chk("rd_out valid", m_valid, 1);
    chk("rd_out data", m_data, expected(1, 0));
    apply_reset(1'b1);

    // Clean frame with every residue saturated.
    for (int b = 0; b < 4; b++) coef[b] = modulus(b) - 1;
    load_frame(2, 1'b0);
    read_frame(2, 1'b0, 5, 1);

    chk("reset/op exclusive", excl_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
